// File: rtl/read_channel_scheduler_if.sv
// Bundle of requester-side and external AXI read-channel signals for read_channel_scheduler.
// master: the scheduler's view; slave: the environment (requesters plus external memory).
interface read_channel_scheduler_if #(
    parameter int NUM_MASTERS = 3,
    parameter int ADDR_W      = 26,
    parameter int DATA_W      = 32
);
    logic [NUM_MASTERS-1:0]        m_arvalid;
    logic [NUM_MASTERS*ADDR_W-1:0] m_araddr;
    logic [NUM_MASTERS*4-1:0]      m_arlen;
    logic [NUM_MASTERS-1:0]        m_arready;
    logic [NUM_MASTERS-1:0]        m_rvalid;
    logic                          m_rlast;
    logic [DATA_W-1:0]             m_rdata;
    logic [NUM_MASTERS-1:0]        m_rready;
    logic                          ARVALID;
    logic                          ARREADY;
    logic [3:0]                    ARID;
    logic [3:0]                    ARLEN;
    logic [ADDR_W-1:0]             ARADDR;
    logic                          RVALID;
    logic                          RLAST;
    logic [3:0]                    RID;
    logic [DATA_W-1:0]             RDATA;
    logic                          RREADY;
    logic                          err_rid;
    logic                          err_len;

    modport master (
        input  m_arvalid, m_araddr, m_arlen, m_rready, ARREADY, RVALID, RLAST, RID, RDATA,
        output m_arready, m_rvalid, m_rlast, m_rdata, ARVALID, ARID, ARLEN, ARADDR, RREADY,
               err_rid, err_len
    );

    modport slave (
        output m_arvalid, m_araddr, m_arlen, m_rready, ARREADY, RVALID, RLAST, RID, RDATA,
        input  m_arready, m_rvalid, m_rlast, m_rdata, ARVALID, ARID, ARLEN, ARADDR, RREADY,
               err_rid, err_len
    );
endinterface

// File: rtl/read_channel_scheduler.sv
// Shares one AXI read channel among NUM_MASTERS requesters, one burst at a time, tagged by ARID.
// Define READ_SCHED_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority (index 0 first).
module read_channel_scheduler #(
    parameter int NUM_MASTERS = 3,
    parameter int ADDR_W      = 26,
    parameter int DATA_W      = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    read_channel_scheduler_if.master bus
);
    localparam int IDX_W = $clog2(NUM_MASTERS);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       owner_q, owner_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [3:0]             len_q, len_d;
    logic [4:0]             cnt_q, cnt_d;
    logic [NUM_MASTERS-1:0] arready_q, arready_d;
    logic                   err_rid_q, err_rid_d;
    logic                   err_len_q, err_len_d;

    logic                   any_req;
    logic [IDX_W-1:0]       winner;
    logic                   rid_match;
    logic                   owner_ready;
    logic                   rvalid_own;
    logic                   beat_ok;

    logic [ADDR_W-1:0]      addr_slice [NUM_MASTERS];
    logic [3:0]             len_slice  [NUM_MASTERS];

    generate
        for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_master
            assign addr_slice[gi]   = bus.m_araddr[gi*ADDR_W +: ADDR_W];
            assign len_slice[gi]    = bus.m_arlen[gi*4 +: 4];
            assign bus.m_rvalid[gi] = rvalid_own && (owner_q == IDX_W'(gi));
        end
    endgenerate

`ifdef READ_SCHED_ROUND_ROBIN_EN
    logic [IDX_W-1:0] rr_q, rr_d;
    logic             found;

    // Search starts at the pointer and wraps; the first requester found wins.
    always_comb begin
        any_req = |bus.m_arvalid;
        winner  = rr_q;
        found   = 1'b0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (!found && bus.m_arvalid[(int'(rr_q) + k) % NUM_MASTERS]) begin
                winner = IDX_W'((int'(rr_q) + k) % NUM_MASTERS);
                found  = 1'b1;
            end
        end
    end
`else
    always_comb begin
        any_req = |bus.m_arvalid;
        winner  = '0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (bus.m_arvalid[i]) winner = IDX_W'(i);
        end
    end
`endif

    // R path is purely combinational; foreign-ID beats are drained regardless of the owner's ready.
    assign rid_match   = (bus.RID == 4'(owner_q));
    assign owner_ready = bus.m_rready[owner_q];
    assign rvalid_own  = (state_q == DATA) && bus.RVALID && rid_match;
    assign beat_ok     = rvalid_own && owner_ready;

    assign bus.RREADY    = (state_q == DATA) && (rid_match ? owner_ready : 1'b1);
    assign bus.m_rdata   = bus.RDATA;
    assign bus.m_rlast   = bus.RLAST;
    assign bus.m_arready = arready_q;
    assign bus.ARVALID   = (state_q == ADDR);
    assign bus.ARID      = 4'(owner_q);
    assign bus.ARADDR    = addr_q;
    assign bus.ARLEN     = len_q;
    assign bus.err_rid   = err_rid_q;
    assign bus.err_len   = err_len_q;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        addr_d    = addr_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        arready_d = '0;
        err_rid_d = err_rid_q;
        err_len_d = err_len_q;
`ifdef READ_SCHED_ROUND_ROBIN_EN
        rr_d      = rr_q;
`endif
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    owner_d   = winner;
                    addr_d    = addr_slice[winner];
                    len_d     = len_slice[winner];
                    arready_d = NUM_MASTERS'(1) << winner;
                    state_d   = ADDR;
`ifdef READ_SCHED_ROUND_ROBIN_EN
                    rr_d      = (winner == IDX_W'(NUM_MASTERS - 1)) ? '0 : winner + IDX_W'(1);
`endif
                end
            end
            ADDR: begin
                if (bus.ARREADY) begin
                    cnt_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bus.RVALID && !rid_match) err_rid_d = 1'b1;
                if (beat_ok) begin
                    cnt_d = cnt_q + 5'd1;
                    // Short burst ends early; overrun flags once but waits for RLAST.
                    if (bus.RLAST) begin
                        state_d = IDLE;
                        if (cnt_q != {1'b0, len_q}) err_len_d = 1'b1;
                    end else if (cnt_q == {1'b0, len_q}) begin
                        err_len_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            arready_q <= '0;
            err_rid_q <= 1'b0;
            err_len_q <= 1'b0;
`ifdef READ_SCHED_ROUND_ROBIN_EN
            rr_q      <= '0;
`endif
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            arready_q <= arready_d;
            err_rid_q <= err_rid_d;
            err_len_q <= err_len_d;
`ifdef READ_SCHED_ROUND_ROBIN_EN
            rr_q      <= rr_d;
`endif
        end
    end
endmodule

// File: tb/tb_read_channel_scheduler.sv
// Directed bench for read_channel_scheduler: a table of single bursts plus hand-written
// sequences for arbitration order, backpressure, overrun and mid-burst reset.
module tb_read_channel_scheduler;
    localparam int NM = 3;
    localparam int AW = 26;
    localparam int DW = 32;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    read_channel_scheduler_if #(.NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW)) bus ();

    read_channel_scheduler #(.NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          m;
        logic [25:0] addr;
        int          len;
        int          stall;
        int          last_at;
        int          foreign_at;
        int          foreign_id;
        bit          exp_err_len;
        bit          exp_err_rid;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        bus.m_arvalid = '0;
        bus.m_araddr  = '0;
        bus.m_arlen   = '0;
        bus.m_rready  = '0;
        bus.ARREADY   = 1'b0;
        bus.RVALID    = 1'b0;
        bus.RLAST     = 1'b0;
        bus.RID       = '0;
        bus.RDATA     = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // One full burst from a table entry, checked cycle by cycle.
    task automatic run_burst(input vec_t t);
        int          owner_beats;
        int          slot;
        bit          foreign;
        logic        lst;
        logic [31:0] d;
        bus.m_arvalid                = '0;
        bus.m_arvalid[t.m]           = 1'b1;
        bus.m_araddr[t.m*AW +: AW]   = t.addr;
        bus.m_arlen[t.m*4 +: 4]      = 4'(t.len);
        bus.ARREADY                  = 1'b0;
        bus.m_rready                 = '1;
        @(negedge clk);
        chk("pre_grant", 64'(bus.m_arready), 64'd0);
        @(posedge clk); #1;
        for (int s = 0; s <= t.stall; s++) begin
            bus.ARREADY = (s == t.stall);
            @(negedge clk);
            chk("arvalid", 64'(bus.ARVALID), 64'd1);
            chk("arid", 64'(bus.ARID), 64'(t.m));
            chk("araddr", 64'(bus.ARADDR), 64'(t.addr));
            chk("arlen", 64'(bus.ARLEN), 64'(t.len));
            chk("m_arready", 64'(bus.m_arready), (s == 0) ? 64'(1 << t.m) : 64'd0);
            @(posedge clk); #1;
            bus.m_arvalid = '0;
        end
        bus.ARREADY = 1'b0;
        owner_beats = 0;
        slot        = 0;
        while (owner_beats <= t.last_at) begin
            foreign      = (slot == t.foreign_at);
            lst          = !foreign && (owner_beats == t.last_at);
            d            = 32'hD000_0000 | 32'(t.m << 8) | 32'(slot);
            bus.RVALID   = 1'b1;
            bus.RID      = foreign ? 4'(t.foreign_id) : 4'(t.m);
            bus.RDATA    = d;
            bus.RLAST    = lst;
            bus.m_rready = foreign ? '0 : '1;
            @(negedge clk);
            chk("m_rdata", 64'(bus.m_rdata), 64'(d));
            chk("m_rlast", 64'(bus.m_rlast), 64'(lst));
            chk("rready", 64'(bus.RREADY), 64'd1);
            chk("m_rvalid", 64'(bus.m_rvalid), foreign ? 64'd0 : 64'(1 << t.m));
            @(posedge clk); #1;
            if (!foreign) owner_beats++;
            slot++;
        end
        bus.RVALID   = 1'b0;
        bus.RLAST    = 1'b0;
        bus.m_rready = '1;
        @(negedge clk);
        chk("idle_arvalid", 64'(bus.ARVALID), 64'd0);
        chk("idle_rready", 64'(bus.RREADY), 64'd0);
        chk("err_len", 64'(bus.err_len), 64'(t.exp_err_len));
        chk("err_rid", 64'(bus.err_rid), 64'(t.exp_err_rid));
        @(posedge clk); #1;
    endtask

    // Wait (bounded) for the next grant, expect it for exp_m, then run a one-beat burst.
    task automatic serve_one(input int exp_m);
        bit got;
        got = 1'b0;
        for (int c = 0; c < 6 && !got; c++) begin
            @(negedge clk);
            if (bus.m_arready != '0) got = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        chk("grant_seen", 64'(got), 64'd1);
        chk("grant", 64'(bus.m_arready), 64'(1 << exp_m));
        chk("grant_arid", 64'(bus.ARID), 64'(exp_m));
        @(posedge clk); #1;
        bus.m_arvalid[exp_m] = 1'b0;
        bus.RVALID   = 1'b1;
        bus.RID      = 4'(exp_m);
        bus.RLAST    = 1'b1;
        bus.RDATA    = 32'h5A00_0000 | 32'(exp_m);
        bus.m_rready = '1;
        @(negedge clk);
        chk("serve_rvalid", 64'(bus.m_rvalid), 64'(1 << exp_m));
        @(posedge clk); #1;
        bus.RVALID = 1'b0;
        bus.RLAST  = 1'b0;
        @(negedge clk);
        chk("bubble_arvalid", 64'(bus.ARVALID), 64'd0);
        chk("bubble_arready", 64'(bus.m_arready), 64'd0);
        @(posedge clk); #1;
        $display("serve master=%0d granted=%0d", exp_m, got);
    endtask

    // Request from master m with ARREADY high; returns in DATA.
    task automatic start_burst(input int m, input logic [25:0] a, input int len);
        bus.m_arvalid            = '0;
        bus.m_arvalid[m]         = 1'b1;
        bus.m_araddr[m*AW +: AW] = a;
        bus.m_arlen[m*4 +: 4]    = 4'(len);
        bus.ARREADY              = 1'b1;
        bus.m_rready             = '1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.m_arvalid = '0;
        bus.ARREADY   = 1'b0;
    endtask

    task automatic beat(input int m, input logic [31:0] d, input logic lst);
        bus.RVALID = 1'b1;
        bus.RID    = 4'(m);
        bus.RDATA  = d;
        bus.RLAST  = lst;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int order [3];
        total = 0;
        bad   = 0;

        //            m  addr         len stall last foreign fid errlen errrid
        vecs[0] = '{1, 26'h0000400, 3, 2, 3, -1, 0, 1'b0, 1'b0};
        vecs[1] = '{2, 26'h0001234, 3, 0, 3,  1, 0, 1'b0, 1'b1};
        vecs[2] = '{0, 26'h3FFFFFC, 3, 1, 1, -1, 0, 1'b1, 1'b0};
        vecs[3] = '{0, 26'h0000010, 0, 0, 0, -1, 0, 1'b0, 1'b0};
        vecs[4] = '{2, 26'h2000000, 15, 0, 15, -1, 0, 1'b0, 1'b0};

        // Reset state and pass-through; beats in IDLE are not accepted.
        do_reset();
        bus.RVALID = 1'b1;
        bus.RID    = 4'd3;
        bus.RLAST  = 1'b1;
        bus.RDATA  = 32'hA5A5_0F0F;
        bus.m_rready = '1;
        @(negedge clk);
        chk("rst_arvalid", 64'(bus.ARVALID), 64'd0);
        chk("rst_arid", 64'(bus.ARID), 64'd0);
        chk("rst_araddr", 64'(bus.ARADDR), 64'd0);
        chk("rst_arlen", 64'(bus.ARLEN), 64'd0);
        chk("rst_m_arready", 64'(bus.m_arready), 64'd0);
        chk("rst_m_rvalid", 64'(bus.m_rvalid), 64'd0);
        chk("rst_rready", 64'(bus.RREADY), 64'd0);
        chk("rst_err_rid", 64'(bus.err_rid), 64'd0);
        chk("rst_err_len", 64'(bus.err_len), 64'd0);
        chk("pass_rdata", 64'(bus.m_rdata), 64'h0000_0000_A5A5_0F0F);
        chk("pass_rlast", 64'(bus.m_rlast), 64'd1);
        $display("reset state checked");

        for (int v = 0; v < 5; v++) begin
            do_reset();
            run_burst(vecs[v]);
            $display("burst %0d master=%0d len=%0d stall=%0d done", v, vecs[v].m, vecs[v].len, vecs[v].stall);
        end

        // Simultaneous requests after one grant to master 0.
`ifdef READ_SCHED_ROUND_ROBIN_EN
        order[0] = 1; order[1] = 2; order[2] = 0;
`else
        order[0] = 0; order[1] = 1; order[2] = 2;
`endif
        do_reset();
        bus.ARREADY  = 1'b1;
        bus.m_araddr = {26'h0000300, 26'h0000200, 26'h0000100};
        bus.m_arlen  = '0;
        bus.m_arvalid[0] = 1'b1;
        serve_one(0);
        bus.m_arvalid = 3'b111;
        for (int k = 0; k < 3; k++) serve_one(order[k]);
        bus.ARREADY = 1'b0;
        $display("arbitration order %0d %0d %0d checked", order[0], order[1], order[2]);

        // Backpressure: owner not ready for 3 cycles, no beat lost, count unchanged.
        do_reset();
        start_burst(0, 26'h0000080, 3);
        beat(0, 32'h1000_0000, 1'b0);
        @(negedge clk);
        chk("bp_beat0", 64'(bus.m_rvalid), 64'd1);
        @(posedge clk); #1;
        beat(0, 32'h1000_0001, 1'b0);
        bus.m_rready = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("bp_rready_low", 64'(bus.RREADY), 64'd0);
            chk("bp_rvalid_held", 64'(bus.m_rvalid), 64'd1);
            @(posedge clk); #1;
        end
        bus.m_rready = '1;
        for (int b = 1; b <= 3; b++) begin
            beat(0, 32'h1000_0000 | 32'(b), b == 3);
            @(negedge clk);
            chk("bp_rready", 64'(bus.RREADY), 64'd1);
            chk("bp_rdata", 64'(bus.m_rdata), 64'(32'h1000_0000 | 32'(b)));
            @(posedge clk); #1;
        end
        bus.RVALID = 1'b0;
        bus.RLAST  = 1'b0;
        @(negedge clk);
        chk("bp_idle_rready", 64'(bus.RREADY), 64'd0);
        chk("bp_err_len", 64'(bus.err_len), 64'd0);
        @(posedge clk); #1;
        $display("backpressure burst done");

        // Overrun: ARLEN=1, second beat without RLAST.
        do_reset();
        start_burst(1, 26'h0000040, 1);
        beat(1, 32'h2000_0000, 1'b0);
        @(posedge clk); #1;
        bus.RVALID = 1'b0;
        @(negedge clk);
        chk("ovr_err_len_beat1", 64'(bus.err_len), 64'd0);
        @(posedge clk); #1;
        beat(1, 32'h2000_0001, 1'b0);
        @(posedge clk); #1;
        bus.RVALID = 1'b0;
        @(negedge clk);
        chk("ovr_err_len", 64'(bus.err_len), 64'd1);
        chk("ovr_still_data", 64'(bus.RREADY), 64'd1);
        chk("ovr_arvalid", 64'(bus.ARVALID), 64'd0);
        @(posedge clk); #1;
        beat(1, 32'h2000_0002, 1'b1);
        @(posedge clk); #1;
        bus.RVALID = 1'b0;
        bus.RLAST  = 1'b0;
        @(negedge clk);
        chk("ovr_idle", 64'(bus.RREADY), 64'd0);
        chk("ovr_err_sticky", 64'(bus.err_len), 64'd1);
        @(posedge clk); #1;
        $display("overrun burst done");

        // Reset after 1 of 4 beats, then a fresh grant.
        do_reset();
        start_burst(2, 26'h0000ABC, 3);
        beat(2, 32'h3000_0000, 1'b0);
        @(posedge clk); #1;
        beat(2, 32'h3000_0001, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mr_arvalid", 64'(bus.ARVALID), 64'd0);
        chk("mr_arid", 64'(bus.ARID), 64'd0);
        chk("mr_araddr", 64'(bus.ARADDR), 64'd0);
        chk("mr_arlen", 64'(bus.ARLEN), 64'd0);
        chk("mr_m_rvalid", 64'(bus.m_rvalid), 64'd0);
        chk("mr_rready", 64'(bus.RREADY), 64'd0);
        chk("mr_m_arready", 64'(bus.m_arready), 64'd0);
        chk("mr_errs", 64'({bus.err_rid, bus.err_len}), 64'd0);
        @(posedge clk); #1;
        bus.RVALID   = 1'b0;
        bus.ARREADY  = 1'b1;
        bus.m_arvalid[1] = 1'b1;
        serve_one(1);
        $display("mid-burst reset sequence done");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
